// File: rtl/fnd_scan_ctrl.sv
// 4-digit multiplexed 7-segment driver: sequential double-dabble converts count_data
// to BCD every 16 cycles, and a scan divider strobes one active-low digit at a time.
module fnd_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 100_000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] count_data,
  output logic [3:0]  fnd_com,
  output logic [7:0]  fnd_data,
  output logic        conv_busy
);

  localparam int unsigned BIN_W     = 14;
  localparam int unsigned BCD_W     = 16;
  localparam int unsigned STEP_W    = 4;
  localparam int unsigned STEP_LAST = 13;
  localparam int unsigned MAX_VAL   = 9999;
  localparam int unsigned DIV_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q;
  logic [BIN_W-1:0]   bin_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   bcd_adj_c;
  logic [BCD_W-1:0]   disp_q;
  logic [STEP_W-1:0]  step_q;
  logic [DIV_W-1:0]   div_q;
  logic [1:0]         sel_q;
  logic               tick_c;
  logic [3:0]         digit_c;
  logic               blank_c;
  logic [7:0]         seg_c;

  // Add-3 correction on every BCD nibble ahead of the shift
  always_comb begin
    bcd_adj_c = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Conversion FSM; conv_busy tracks SHIFT/DONE on the same edge as the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      step_q    <= '0;
      disp_q    <= '0;
      conv_busy <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          bin_q     <= (count_data > BIN_W'(MAX_VAL)) ? BIN_W'(MAX_VAL) : count_data;
          bcd_q     <= '0;
          step_q    <= '0;
          state_q   <= SHIFT;
          conv_busy <= 1'b1;
        end
        SHIFT: begin
          bcd_q  <= {bcd_adj_c[BCD_W-2:0], bin_q[BIN_W-1]};
          bin_q  <= {bin_q[BIN_W-2:0], 1'b0};
          step_q <= step_q + STEP_W'(1);
          if (step_q == STEP_W'(STEP_LAST)) state_q <= DONE;
        end
        DONE: begin
          disp_q    <= bcd_q;
          state_q   <= IDLE;
          conv_busy <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          conv_busy <= 1'b0;
        end
      endcase
    end
  end

  assign tick_c = (div_q == DIV_W'(SCAN_DIV - 1));

  // Scan divider and digit select
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      sel_q <= '0;
    end else if (tick_c) begin
      div_q <= '0;
      sel_q <= sel_q + 2'd1;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Digit pick, leading-zero blanking and segment lookup
  always_comb begin
    digit_c = disp_q[{sel_q, 2'b00} +: 4];
    case (sel_q)
      2'd3:    blank_c = BLANK_LZ && (disp_q[15:12] == 4'd0);
      2'd2:    blank_c = BLANK_LZ && (disp_q[15:8]  == 8'd0);
      2'd1:    blank_c = BLANK_LZ && (disp_q[15:4]  == 12'd0);
      default: blank_c = 1'b0;
    endcase
    case (digit_c)
      4'd0:    seg_c = 8'hC0;
      4'd1:    seg_c = 8'hF9;
      4'd2:    seg_c = 8'hA4;
      4'd3:    seg_c = 8'hB0;
      4'd4:    seg_c = 8'h99;
      4'd5:    seg_c = 8'h92;
      4'd6:    seg_c = 8'h82;
      4'd7:    seg_c = 8'hF8;
      4'd8:    seg_c = 8'h80;
      4'd9:    seg_c = 8'h90;
      default: seg_c = 8'hFF;
    endcase
    if (blank_c) seg_c = 8'hFF;
  end

  // Digit enable and segments registered together from the same select
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fnd_com  <= 4'b1111;
      fnd_data <= 8'hFF;
    end else begin
      fnd_com  <= ~(4'b0001 << sel_q);
      fnd_data <= seg_c;
    end
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl: two instances (blanking on/off) share stimulus.
module tb_fnd_scan_ctrl;

  localparam int unsigned SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] count_data;
  logic [3:0]  com_a, com_b;
  logic [7:0]  data_a, data_b;
  logic        busy_a, busy_b;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] com;
    logic [7:0] da;
    logic [7:0] db;
  } exp_t;
  exp_t sb[$];

  fnd_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b1)) dut_a (
    .clk(clk), .reset(reset), .count_data(count_data),
    .fnd_com(com_a), .fnd_data(data_a), .conv_busy(busy_a));

  fnd_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b0)) dut_b (
    .clk(clk), .reset(reset), .count_data(count_data),
    .fnd_com(com_b), .fnd_data(data_b), .conv_busy(busy_b));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: return 8'hC0; 1: return 8'hF9; 2: return 8'hA4; 3: return 8'hB0;
      4: return 8'h99; 5: return 8'h92; 6: return 8'h82; 7: return 8'hF8;
      8: return 8'h80; 9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic int sat(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic logic [7:0] exp_seg(input int v, input int pos, input bit blz);
    int vs = sat(v);
    int p = 1;
    for (int k = 0; k < pos; k++) p = p * 10;
    if (blz && pos > 0 && vs < p) return 8'hFF;
    return seg_of((vs / p) % 10);
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    int vs = sat(v);
    return {4'(vs / 1000), 4'((vs / 100) % 10), 4'((vs / 10) % 10), 4'(vs % 10)};
  endfunction

  task automatic push_frame(input int v);
    logic [3:0] com_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_t e;
    for (int pos = 0; pos < 4; pos++) begin
      e.com = com_tab[pos];
      e.da  = exp_seg(v, pos, 1'b1);
      e.db  = exp_seg(v, pos, 1'b0);
      sb.push_back(e);
    end
  endtask

  // Align on the ones-digit slot, then pop one expectation per digit slot
  task automatic run_frame(input string tag);
    int n = 0;
    exp_t e;
    while (com_a !== 4'b1110 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) check({tag, "_sync_timeout"}, 32'(com_a), 32'hE);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_com_a"},  32'(com_a),  32'(e.com));
      check({tag, "_com_b"},  32'(com_b),  32'(e.com));
      check({tag, "_data_a"}, 32'(data_a), 32'(e.da));
      check({tag, "_data_b"}, 32'(data_b), 32'(e.db));
      repeat (SCAN_DIV) @(negedge clk);
    end
  endtask

  task automatic apply(input int v, input string tag);
    count_data = 14'(v);
    repeat (33) @(negedge clk);
    check({tag, "_disp"}, 32'(dut_a.disp_q), 32'(to_bcd(v)));
    push_frame(v);
    run_frame(tag);
  endtask

  // conv_busy must drop for exactly one cycle out of every 16
  int  gap = 0;
  bit  have_prev = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      have_prev = 1'b0;
      gap = 0;
    end else begin
      gap++;
      if (!busy_a) begin
        if (have_prev) check("busy_gap", 32'(gap), 32'd16);
        have_prev = 1'b1;
        gap = 0;
      end
    end
  end

  initial begin
    int n;
    exp_t e;
    reset = 1'b1;
    count_data = '0;
    repeat (3) @(negedge clk);
    check("rst_com",  32'(com_a),  32'hF);
    check("rst_data", 32'(data_a), 32'hFF);
    check("rst_busy", 32'(busy_a), 32'h0);
    check("rst_disp", 32'(dut_a.disp_q), 32'h0);

    reset = 1'b0;
    @(negedge clk);
    check("first_com",  32'(com_a),  32'hE);
    check("first_data", 32'(data_a), 32'hC0);

    apply(1234, "v1234");
    apply(7, "v7");
    apply(0, "v0");
    apply(405, "v405");
    apply(9999, "v9999");
    apply(10000, "v10000");
    apply(16383, "v16383");

    for (int v = 0; v <= 9999; v += 137) begin
      count_data = 14'(v);
      repeat (32) @(negedge clk);
      check("sweep_disp", 32'(dut_a.disp_q), 32'(to_bcd(v)));
    end
    foreach (sb[i]) sb.delete(i);
    count_data = 14'd9999;
    repeat (32) @(negedge clk);
    check("sweep_9999", 32'(dut_a.disp_q), 32'h9999);
    count_data = 14'd0;
    repeat (32) @(negedge clk);
    check("sweep_0", 32'(dut_a.disp_q), 32'h0);

    // Reset in the middle of a conversion of 42
    count_data = 14'd42;
    repeat (40) @(negedge clk);
    check("pre_rst_disp", 32'(dut_a.disp_q), 32'h0042);
    n = 0;
    while (busy_a !== 1'b1 && n < 32) begin
      @(negedge clk);
      n++;
    end
    if (n >= 32) check("busy_timeout", 32'(busy_a), 32'h1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_com",  32'(com_a),  32'hF);
    check("mid_rst_data", 32'(data_a), 32'hFF);
    check("mid_rst_busy", 32'(busy_a), 32'h0);
    check("mid_rst_disp", 32'(dut_a.disp_q), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    push_frame(0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check("post_rst_com_a",  32'(com_a),  32'(e.com));
      check("post_rst_data_a", 32'(data_a), 32'(e.da));
      check("post_rst_data_b", 32'(data_b), 32'(e.db));
      repeat (SCAN_DIV) @(negedge clk);
    end
    push_frame(42);
    run_frame("post_rst_42");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
